// File: rtl/fsk_mod.sv
// fsk_mod: FSK modulation stage between the packet transmitter and the DCO.
// It queues serial bits from the transmitter in a 4-entry FIFO and turns each
// bit into a frequency control word centre +/- FDEV. It also sequences the PA
// enable through warm-up, modulation and ramp-down.
// Optional build macro: FSK_MOD_SHAPING_EN. When defined, the offset ramps
// linearly at DEV_STEP per clock. Otherwise, the offset jumps straight to its
// target.
module fsk_mod #(
    parameter int CLK_PER_BIT = 16,
    parameter int FCW_W       = 16,
    parameter int CH_IDX_W    = 6,
    parameter int CH_BASE     = 1000,
    parameter int CH_STEP     = 64,
    parameter int DEV_STEP    = 4,
    parameter int RAMP_LEN    = 4,
    parameter int WARMUP_CYC  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CH_IDX_W-1:0] ch_idx,
    input  logic                tx,
    input  logic                tx_valid,
    output logic [FCW_W-1:0]    fcw,
    output logic                fcw_valid,
    output logic                pa_en,
    output logic                busy,
    output logic                overflow
);

    localparam int FDEV   = DEV_STEP * RAMP_LEN;
    localparam int OFF_W  = $clog2(FDEV + 1) + 1;
    localparam int BIT_W  = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        MOD,
        RAMPDN
    } state_t;

    // Bit FIFO
    logic       mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] count;
    logic [2:0] count_n;
    logic       push;
    logic       push_ok;
    logic       pop;
    logic       full;
    logic       head;

    // Modulator state
    state_t                    state;
    state_t                    state_n;
    logic signed [OFF_W-1:0]   offset;
    logic signed [OFF_W-1:0]   offset_n;
    logic signed [OFF_W-1:0]   target;
    logic signed [OFF_W-1:0]   target_n;
    logic [BIT_W-1:0]          bit_cnt;
    logic [BIT_W-1:0]          bit_cnt_n;
    logic [WARM_W-1:0]         warm_cnt;
    logic [WARM_W-1:0]         warm_cnt_n;
    logic [CH_IDX_W-1:0]       ch_lat;
    logic [CH_IDX_W-1:0]       ch_lat_n;
    logic [FCW_W-1:0]          fcw_n;

    // Move cur toward tgt, either one DEV_STEP at a time or in a single jump.
    function automatic logic signed [OFF_W-1:0] step_toward(
        input logic signed [OFF_W-1:0] cur,
        input logic signed [OFF_W-1:0] tgt
    );
`ifdef FSK_MOD_SHAPING_EN
        int c;
        int t;
        c = int'(cur);
        t = int'(tgt);
        if (c < t) begin
            c = (c + DEV_STEP > t) ? t : c + DEV_STEP;
        end else if (c > t) begin
            c = (c - DEV_STEP < t) ? t : c - DEV_STEP;
        end
        return OFF_W'(c);
`else
        return (cur == tgt) ? cur : tgt;
`endif
    endfunction

    // The push is qualified here, and the pop comes from the state machine.
    // A pop frees a slot for a push that arrives in the same cycle.
    assign push    = tx_valid && en;
    assign full    = (count == 3'd4);
    assign push_ok = push && (!full || pop);
    assign head    = mem[rd_ptr];
    assign count_n = count + 3'(push_ok) - 3'(pop);

    // Next-state, offset and counter decode for the modulator sequence
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_n    = state;
        offset_n   = offset;
        target_n   = target;
        bit_cnt_n  = bit_cnt;
        warm_cnt_n = warm_cnt;
        ch_lat_n   = ch_lat;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                offset_n = '0;
                if (count != 3'd0) begin
                    state_n    = WARMUP;
                    ch_lat_n   = ch_idx;
                    warm_cnt_n = '0;
                end
            end
            WARMUP: begin
                offset_n = '0;
                if (warm_cnt == WARM_W'(WARMUP_CYC - 1)) begin
                    state_n   = MOD;
                    bit_cnt_n = '0;
                end else begin
                    warm_cnt_n = warm_cnt + 1'b1;
                end
            end
            MOD: begin
                if (bit_cnt == '0) begin
                    if (count != 3'd0) begin
                        pop      = 1'b1;
                        target_n = head ? OFF_W'(FDEV) : OFF_W'(-FDEV);
                    end else begin
                        // Underrun marks the end of the packet, so start heading home.
                        state_n  = RAMPDN;
                        target_n = '0;
                    end
                end
                offset_n  = step_toward(offset, target_n);
                bit_cnt_n = (bit_cnt == BIT_W'(CLK_PER_BIT - 1)) ? '0 : bit_cnt + 1'b1;
            end
            RAMPDN: begin
                if (offset == '0) begin
                    state_n = IDLE;
                end else begin
                    offset_n = step_toward(offset, '0);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (!en) begin
            state_n  = IDLE;
            offset_n = '0;
            pop      = 1'b0;
        end
    end

    // Frequency word for the next cycle: the channel base plus the signed offset, wrapped to FCW_W
    always_comb begin
        fcw_n = FCW_W'(CH_BASE + int'(ch_lat_n) * CH_STEP + int'(offset_n));
    end

    // Modulator state register with outputs registered from the next-state values
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            offset    <= '0;
            target    <= '0;
            bit_cnt   <= '0;
            warm_cnt  <= '0;
            ch_lat    <= '0;
            fcw       <= '0;
            fcw_valid <= 1'b0;
            pa_en     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            offset    <= offset_n;
            target    <= target_n;
            bit_cnt   <= bit_cnt_n;
            warm_cnt  <= warm_cnt_n;
            ch_lat    <= ch_lat_n;
            fcw       <= (state_n == IDLE) ? '0 : fcw_n;
            fcw_valid <= (state_n != IDLE);
            pa_en     <= (state_n != IDLE);
            busy      <= (state_n != IDLE);
        end
    end

    // FIFO pointers, occupancy and sticky overflow. Dropping en flushes all of them.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            count <= count_n;
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count define which entries are valid.
        if (push_ok) begin
            mem[wr_ptr] <= tx;
        end
    end

endmodule
